// File: rtl/jump_traj_pkg.sv
// Shared types, widths and saturation helpers for the jump trajectory engine.
package jump_traj_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned V_W        = 12;
  localparam int unsigned H_ACC_W    = 22;
  localparam int unsigned D_ACC_W    = 17;
  localparam int unsigned FRAC       = 4;
  localparam int unsigned V_IN_W     = 11;
  localparam int unsigned HEIGHT_W   = 9;
  localparam int unsigned DIST_W     = 11;
  localparam int unsigned HEIGHT_MAX = 511;
  localparam int unsigned DIST_MAX   = 2047;

  // Fixed-point accumulator to whole pixels, clamped to the output range.
  function automatic logic [HEIGHT_W-1:0] sat_height(input logic [H_ACC_W-1:0] acc);
    logic [H_ACC_W-FRAC-1:0] px;
    px = acc[H_ACC_W-1:FRAC];
    if (px > (H_ACC_W-FRAC)'(HEIGHT_MAX)) return HEIGHT_W'(HEIGHT_MAX);
    return px[HEIGHT_W-1:0];
  endfunction

  function automatic logic [DIST_W-1:0] sat_dist(input logic [D_ACC_W-1:0] acc);
    logic [D_ACC_W-FRAC-1:0] px;
    px = acc[D_ACC_W-1:FRAC];
    if (px > (D_ACC_W-FRAC)'(DIST_MAX)) return DIST_W'(DIST_MAX);
    return px[DIST_W-1:0];
  endfunction

endpackage

// File: rtl/jump_tick_gen.sv
// Physics tick divider: one-cycle o_tick_c every TICK_DIV enabled cycles.
module jump_tick_gen #(
  parameter int unsigned TICK_DIV = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter rests at zero whenever the engine is not flying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/jump_traj_engine.sv
// Ballistic jump integrator answering the jump FSM's request handshake.
// Optional apex pulse output enabled by defining JUMP_TRAJ_APEX_EN.
module jump_traj_engine
  import jump_traj_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1048576,
  parameter int unsigned GRAV     = 1,
  parameter int unsigned H_STEP   = 32
) (
  input  logic        clk_machine,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [10:0] i_v_init,
  output logic [8:0]  o_height,
  output logic [10:0] o_dist,
  output logic        o_done,
  output logic        o_busy
`ifdef JUMP_TRAJ_APEX_EN
  ,
  output logic        o_apex
`endif
);

  state_t                  r_state;
  logic                    r_en_prev;
  logic signed [V_W-1:0]   r_v;
  logic [H_ACC_W-1:0]      r_h_acc;
  logic [D_ACC_W-1:0]      r_d_acc;
  logic [HEIGHT_W-1:0]     r_height;
  logic [DIST_W-1:0]       r_dist;
  logic                    r_done;
  logic                    r_busy;
`ifdef JUMP_TRAJ_APEX_EN
  logic                    r_apex;
`endif

  logic                    w_rise;
  logic                    w_start;
  logic                    w_abort;
  logic                    w_tick;
  logic signed [H_ACC_W:0] w_h_sum;
  logic [H_ACC_W-1:0]      w_h_next;
  logic signed [V_W-1:0]   w_v_next;
  logic [D_ACC_W:0]        w_d_sum;
  logic [D_ACC_W-1:0]      w_d_next;
  logic                    w_v_nonpos;
  logic                    w_v_next_nonpos;
  logic                    w_land;

  assign w_rise  = i_en && !r_en_prev;
  assign w_start = (r_state == IDLE) && w_rise;
  assign w_abort = (r_state == FLY) && !i_en;

  jump_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk_machine),
    .rst_n    (rst_n),
    .i_clr    (w_start || w_abort),
    .i_en     (r_state == FLY),
    .o_tick_c (w_tick)
  );

  // Signed next-height; its sign decides landing before anything is committed.
  assign w_h_sum         = $signed({1'b0, r_h_acc})
                         + $signed({{(H_ACC_W + 1 - V_W){r_v[V_W-1]}}, r_v});
  assign w_h_next        = w_h_sum[H_ACC_W-1:0];
  assign w_v_next        = r_v - $signed(V_W'(GRAV));
  assign w_v_nonpos      = r_v[V_W-1] || (r_v == '0);
  assign w_v_next_nonpos = w_v_next[V_W-1] || (w_v_next == '0);
  assign w_land          = w_v_nonpos && (w_h_sum[H_ACC_W] || (w_h_sum == '0));
  assign w_d_sum         = {1'b0, r_d_acc} + (D_ACC_W + 1)'(H_STEP);
  assign w_d_next        = w_d_sum[D_ACC_W] ? '1 : w_d_sum[D_ACC_W-1:0];

  always_ff @(posedge clk_machine or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_en_prev <= 1'b1;  // a level already high at reset release is not an edge
      r_v       <= '0;
      r_h_acc   <= '0;
      r_d_acc   <= '0;
      r_height  <= '0;
      r_dist    <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef JUMP_TRAJ_APEX_EN
      r_apex    <= 1'b0;
`endif
    end else begin
      r_en_prev <= i_en;
`ifdef JUMP_TRAJ_APEX_EN
      r_apex    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state  <= FLY;
            r_busy   <= 1'b1;
            r_v      <= $signed({1'b0, i_v_init});
            r_h_acc  <= '0;
            r_d_acc  <= '0;
            r_height <= '0;
            r_dist   <= '0;
          end
        end
        FLY: begin
          if (!i_en) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_h_acc  <= '0;
            r_d_acc  <= '0;
            r_height <= '0;
            r_dist   <= '0;
          end else if (w_tick) begin
            r_d_acc <= w_d_next;
            r_dist  <= sat_dist(w_d_next);
            if (w_land) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_h_acc  <= '0;
              r_height <= '0;
            end else begin
              r_h_acc  <= w_h_next;
              r_v      <= w_v_next;
              r_height <= sat_height(w_h_next);
`ifdef JUMP_TRAJ_APEX_EN
              r_apex   <= !w_v_nonpos && w_v_next_nonpos;
`endif
            end
          end
        end
        DONE: begin
          if (!i_en) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef JUMP_TRAJ_APEX_EN
  // Apex detection is only consumed by the optional pulse output.
  logic w_unused;
  assign w_unused = w_v_next_nonpos;
`endif

  assign o_height = r_height;
  assign o_dist   = r_dist;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
`ifdef JUMP_TRAJ_APEX_EN
  assign o_apex   = r_apex;
`endif

endmodule

// File: tb/tb_jump_traj_engine.sv
// Directed bench for jump_traj_engine with a 4-cycle physics tick.
module tb_jump_traj_engine;

  localparam int unsigned TD = 4;

  logic        clk;
  logic        rst_n;
  logic        i_en;
  logic [10:0] i_v_init;
  logic [8:0]  o_height;
  logic [10:0] o_dist;
  logic        o_done;
  logic        o_busy;
`ifdef JUMP_TRAJ_APEX_EN
  logic        o_apex;
`endif

  int n_checks;
  int n_pass;

  jump_traj_engine #(
    .TICK_DIV (TD),
    .GRAV     (1),
    .H_STEP   (32)
  ) dut (
    .clk_machine (clk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .i_v_init    (i_v_init),
    .o_height    (o_height),
    .o_dist      (o_dist),
    .o_done      (o_done),
    .o_busy      (o_busy)
`ifdef JUMP_TRAJ_APEX_EN
    ,
    .o_apex      (o_apex)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drops i_en for a cycle, raises it with v0, returns at the negedge after the start edge.
  task automatic start_jump(input logic [10:0] v0);
    @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    i_v_init = v0;
    i_en     = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TD) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    i_en     = 1'b0;
    i_v_init = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({o_height, o_dist, o_done, o_busy} !== 22'd0) $display("FAIL reset_outputs: got h=%0d d=%0d done=%0b busy=%0b exp all 0", o_height, o_dist, o_done, o_busy); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal;
    int max_h;
    logic early_done;
    max_h      = 0;
    early_done = 1'b0;
    start_jump(11'd64);
    n_checks++; if (o_busy !== 1'b1) $display("FAIL nom_busy: got %0b exp 1", o_busy); else n_pass++;
    for (int k = 1; k <= 128; k++) begin
      wait_ticks(1);
      if (o_done !== 1'b0) early_done = 1'b1;
      if (int'(o_height) > max_h) max_h = int'(o_height);
      if (k == 1) begin
        n_checks++; if (o_height !== 9'd4 || o_dist !== 11'd2) $display("FAIL nom_tick1: got h=%0d d=%0d exp h=4 d=2", o_height, o_dist); else n_pass++;
      end
      if (k == 63) begin
        n_checks++; if (o_height !== 9'd129) $display("FAIL nom_h63: got %0d exp 129", o_height); else n_pass++;
      end
      if (k == 64 || k == 65) begin
        n_checks++; if (o_height !== 9'd130) $display("FAIL nom_peak_t%0d: got %0d exp 130", k, o_height); else n_pass++;
      end
    end
    n_checks++; if (early_done !== 1'b0) $display("FAIL nom_early_done: got 1 exp 0"); else n_pass++;
    n_checks++; if (max_h !== 130) $display("FAIL nom_max_h: got %0d exp 130", max_h); else n_pass++;
    repeat (TD - 1) @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b1) $display("FAIL nom_pre_land: got done=%0b busy=%0b exp done=0 busy=1", o_done, o_busy); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_dist !== 11'd258 || o_height !== 9'd0) $display("FAIL nom_land: got done=%0b busy=%0b d=%0d h=%0d exp 1 0 258 0", o_done, o_busy, o_dist, o_height); else n_pass++;
  endtask

  task automatic test_hold_release;
    repeat (20) @(negedge clk);
    n_checks++; if (o_done !== 1'b1 || o_dist !== 11'd258) $display("FAIL hold: got done=%0b d=%0d exp 1 258", o_done, o_dist); else n_pass++;
    i_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0 || o_dist !== 11'd258) $display("FAIL release: got done=%0b d=%0d exp 0 258", o_done, o_dist); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (o_dist !== 11'd258 || o_busy !== 1'b0) $display("FAIL release_hold: got d=%0d busy=%0b exp 258 0", o_dist, o_busy); else n_pass++;
  endtask

  task automatic test_v0_zero;
    start_jump(11'd0);
    n_checks++; if (o_dist !== 11'd0 || o_busy !== 1'b1) $display("FAIL v0_start: got d=%0d busy=%0b exp 0 1", o_dist, o_busy); else n_pass++;
    wait_ticks(1);
    n_checks++; if (o_done !== 1'b1 || o_dist !== 11'd2 || o_height !== 9'd0) $display("FAIL v0_land: got done=%0b d=%0d h=%0d exp 1 2 0", o_done, o_dist, o_height); else n_pass++;
  endtask

  task automatic test_abort;
    start_jump(11'd64);
    wait_ticks(10);
    n_checks++; if (o_height !== 9'd37 || o_dist !== 11'd20) $display("FAIL abort_pre: got h=%0d d=%0d exp 37 20", o_height, o_dist); else n_pass++;
    i_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({o_height, o_dist, o_done, o_busy} !== 22'd0) $display("FAIL abort_idle: got h=%0d d=%0d done=%0b busy=%0b exp all 0", o_height, o_dist, o_done, o_busy); else n_pass++;
    repeat (50) @(negedge clk);
    n_checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) $display("FAIL abort_no_done: got done=%0b busy=%0b exp 0 0", o_done, o_busy); else n_pass++;
    start_jump(11'd64);
    i_v_init = 11'd0;
    wait_ticks(1);
    n_checks++; if (o_height !== 9'd4 || o_dist !== 11'd2 || o_busy !== 1'b1) $display("FAIL restart: got h=%0d d=%0d busy=%0b exp 4 2 1", o_height, o_dist, o_busy); else n_pass++;
    i_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int max_h;
    max_h = 0;
    start_jump(11'd2047);
    for (int k = 1; k <= 4094; k++) begin
      wait_ticks(1);
      if (int'(o_height) > max_h) max_h = int'(o_height);
      if (k == 1) begin
        n_checks++; if (o_height !== 9'd127) $display("FAIL sat_tick1: got %0d exp 127", o_height); else n_pass++;
      end
      if (k == 1000) begin
        n_checks++; if (o_dist !== 11'd2000) $display("FAIL sat_d1000: got %0d exp 2000", o_dist); else n_pass++;
      end
      if (k == 1024) begin
        n_checks++; if (o_dist !== 11'd2047) $display("FAIL sat_d1024: got %0d exp 2047", o_dist); else n_pass++;
      end
      if (k == 2047) begin
        n_checks++; if (o_height !== 9'd511) $display("FAIL sat_apex_h: got %0d exp 511", o_height); else n_pass++;
      end
    end
    n_checks++; if (max_h !== 511 || o_done !== 1'b0) $display("FAIL sat_flight: got max_h=%0d done=%0b exp 511 0", max_h, o_done); else n_pass++;
    wait_ticks(1);
    n_checks++; if (o_done !== 1'b1 || o_dist !== 11'd2047 || o_height !== 9'd0) $display("FAIL sat_land: got done=%0b d=%0d h=%0d exp 1 2047 0", o_done, o_dist, o_height); else n_pass++;
  endtask

  task automatic test_reset_midflight;
    start_jump(11'd64);
    wait_ticks(5);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({o_height, o_dist, o_done, o_busy} !== 22'd0) $display("FAIL rst_mid: got h=%0d d=%0d done=%0b busy=%0b exp all 0", o_height, o_dist, o_done, o_busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if ({o_height, o_dist, o_done, o_busy} !== 22'd0) $display("FAIL rst_no_restart: got h=%0d d=%0d done=%0b busy=%0b exp all 0", o_height, o_dist, o_done, o_busy); else n_pass++;
    start_jump(11'd0);
    wait_ticks(1);
    n_checks++; if (o_done !== 1'b1 || o_dist !== 11'd2) $display("FAIL rst_toggle_start: got done=%0b d=%0d exp 1 2", o_done, o_dist); else n_pass++;
  endtask

`ifdef JUMP_TRAJ_APEX_EN
  task automatic test_apex;
    int pulses;
    int at;
    pulses = 0;
    at     = -1;
    start_jump(11'd64);
    for (int c = 1; c <= 4 * 129 + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_apex === 1'b1) begin
        pulses++;
        at = c;
      end
    end
    n_checks++; if (pulses !== 1 || at !== 4 * 64) $display("FAIL apex: got pulses=%0d at=%0d exp 1 at %0d", pulses, at, 4 * 64); else n_pass++;
    start_jump(11'd0);
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_apex === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL apex_v0: got pulses=%0d exp 0", pulses); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset;
    test_nominal;
    test_hold_release;
    test_v0_zero;
    test_abort;
    test_saturation;
    test_reset_midflight;
`ifdef JUMP_TRAJ_APEX_EN
    test_apex;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
